// File: rtl/apb_uart_rx_fifo_slave.sv
// APB slave front-end for the UART receiver.
// Captures words from the rcv_block into an RX FIFO. It also holds sticky error
// flags, the bit_period and data_size configuration, and a registered level
// interrupt.
//
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   rx_data, data_ready - word and valid strobe from the receiver
//   overrun_error,
//   framing_error       - receiver error levels (latched into sticky flags)
//   psel..pwdata        - APB request (zero wait states)
//   prdata, pslverr     - APB response, combinational during the access phase
//   data_read           - one-cycle acknowledge back to the receiver
//   data_size,
//   bit_period          - receiver configuration
//   irq                 - level interrupt (not_empty and/or any error)
module apb_uart_rx_fifo_slave #(
  parameter int DEPTH    = 8,
  parameter int DATA_W   = 8,
  parameter int BP_W     = 14,
  parameter int BP_RESET = 10,
  parameter int DS_RESET = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              data_ready,
  input  logic              overrun_error,
  input  logic              framing_error,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [2:0]        paddr,
  input  logic [7:0]        pwdata,
  output logic [7:0]        prdata,
  output logic              pslverr,
  output logic              data_read,
  output logic [3:0]        data_size,
  output logic [BP_W-1:0]   bit_period,
  output logic              irq
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic {IDLE, ACK} state_t;
  state_t state, state_n;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [AW:0]       count, count_n;
  logic [2:0]        err, err_n;       // {fifo_overflow, overrun, framing}
  logic [1:0]        irq_en, irq_en_n;
  logic [BP_W-1:0]   bit_period_n;
  logic [3:0]        data_size_n;

  logic access, wr_acc, rd_acc, ro_wr;
  logic empty, full, cap, push, pop, ovf;

  assign access = psel & penable;
  assign wr_acc = access & pwrite;
  assign rd_acc = access & ~pwrite;
  assign ro_wr  = wr_acc & ((paddr == 3'd0) | (paddr == 3'd5) | (paddr == 3'd6));

  assign empty = (count == '0);
  assign full  = (count == (AW+1)'(DEPTH));

  // A pop on the same edge frees a slot, so a push into a full FIFO still lands.
  assign pop  = rd_acc & (paddr == 3'd6) & ~empty;
  assign cap  = (state == IDLE) & data_ready;
  assign push = cap & (~full | pop);
  assign ovf  = cap & full & ~pop;

  assign count_n = count + (AW+1)'(push) - (AW+1)'(pop);

  // Capture FSM: the ACK cycle masks data_ready, so each word is taken once.
  always_comb begin
    state_n   = state;
    data_read = 1'b0;
    case (state)
      IDLE: if (data_ready) state_n = ACK;
      ACK: begin
        data_read = 1'b1;
        state_n   = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Register next-state values.
  always_comb begin
    err_n        = err;
    irq_en_n     = irq_en;
    bit_period_n = bit_period;
    data_size_n  = data_size;
    if (wr_acc) begin
      case (paddr)
        3'd1: err_n = err & ~pwdata[2:0];
        3'd2: bit_period_n[7:0] = pwdata;
        3'd3: bit_period_n = {pwdata[BP_W-9:0], bit_period[7:0]};
        3'd4: data_size_n = pwdata[3:0];
        3'd7: irq_en_n = pwdata[1:0];
        default: ;
      endcase
    end
    // Applied after the clear so a new error on the same edge wins.
    err_n = err_n | {ovf, overrun_error, framing_error};
  end

  // APB read mux and error response.
  always_comb begin
    prdata = 8'h00;
    if (rd_acc) begin
      case (paddr)
        3'd0: prdata = {6'b0, full, ~empty};
        3'd1: prdata = {5'b0, err};
        3'd2: prdata = bit_period[7:0];
        3'd3: prdata = 8'(bit_period[BP_W-1:8]);
        3'd4: prdata = {4'b0, data_size};
        3'd5: prdata = 8'(count);
        3'd6: prdata = empty ? 8'h00 : 8'(mem[rd_ptr]);
        3'd7: prdata = {6'b0, irq_en};
        default: prdata = 8'h00;
      endcase
    end
  end

  assign pslverr = ro_wr | (rd_acc & (paddr == 3'd6) & empty);

  // FIFO storage is left unreset; the pointers and count define validity.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= rx_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      err        <= '0;
      irq_en     <= '0;
      bit_period <= BP_W'(BP_RESET);
      data_size  <= 4'(DS_RESET);
      irq        <= 1'b0;
    end else begin
      state      <= state_n;
      count      <= count_n;
      err        <= err_n;
      irq_en     <= irq_en_n;
      bit_period <= bit_period_n;
      data_size  <= data_size_n;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      irq <= (irq_en_n[0] & (count_n != '0)) | (irq_en_n[1] & (|err_n));
    end
  end

endmodule

// File: tb/tb_apb_uart_rx_fifo_slave.sv
module tb_apb_uart_rx_fifo_slave;
  localparam int DEPTH = 8;
  localparam int BPW   = 14;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [7:0]     rx_data = '0;
  logic           data_ready = 1'b0, overrun_error = 1'b0, framing_error = 1'b0;
  logic           psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [2:0]     paddr = '0;
  logic [7:0]     pwdata = '0;
  logic [7:0]     prdata;
  logic           pslverr, data_read, irq;
  logic [3:0]     data_size;
  logic [BPW-1:0] bit_period;

  apb_uart_rx_fifo_slave #(.DEPTH(DEPTH), .DATA_W(8), .BP_W(BPW), .BP_RESET(10), .DS_RESET(8)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .data_ready(data_ready),
    .overrun_error(overrun_error), .framing_error(framing_error),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .prdata(prdata), .pslverr(pslverr), .data_read(data_read),
    .data_size(data_size), .bit_period(bit_period), .irq(irq)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [7:0] last_rd;
  logic       last_err;

  // Reference model: a queue of received words plus register values.
  logic [7:0]     q[$];
  logic [2:0]     m_err;
  logic [1:0]     m_ien;
  logic [BPW-1:0] m_bp;
  logic [3:0]     m_ds;
  bit             m_ack;  // receiver is being acknowledged this cycle
  bit             m_irq;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_rd(input logic [2:0] a);
    case (a)
      3'd0: return {6'b0, q.size() == DEPTH, q.size() != 0};
      3'd1: return {5'b0, m_err};
      3'd2: return m_bp[7:0];
      3'd3: return 8'(m_bp >> 8);
      3'd4: return {4'b0, m_ds};
      3'd5: return 8'(q.size());
      3'd6: return (q.size() != 0) ? q[0] : 8'h00;
      default: return {6'b0, m_ien};
    endcase
  endfunction

  task automatic model_edge();
    bit acc, cap, ovf;
    acc = psel && penable;
    if (rst) begin
      q.delete(); m_err = '0; m_ien = '0; m_bp = 10; m_ds = 8; m_ack = 0; m_irq = 0;
      return;
    end
    cap = !m_ack && data_ready;
    ovf = 0;
    if (acc && !pwrite && paddr == 6 && q.size() != 0) void'(q.pop_front());
    if (cap) begin
      if (q.size() < DEPTH) q.push_back(rx_data);
      else ovf = 1;
    end
    if (acc && pwrite) begin
      case (paddr)
        3'd1: m_err = m_err & ~pwdata[2:0];
        3'd2: m_bp[7:0] = pwdata;
        3'd3: m_bp[BPW-1:8] = pwdata[BPW-9:0];
        3'd4: m_ds = pwdata[3:0];
        3'd7: m_ien = pwdata[1:0];
        default: ;
      endcase
    end
    m_err = m_err | {ovf, overrun_error, framing_error};
    m_ack = cap;
    m_irq = (m_ien[0] && q.size() != 0) || (m_ien[1] && m_err != 0);
  endtask

  // Check every observable output against the model, then advance one clock.
  task automatic step();
    logic [7:0] ep;
    logic       ee;
    bit         acc;
    #1;
    acc = psel && penable;
    last_rd  = prdata;
    last_err = pslverr;
    ep = (acc && !pwrite) ? exp_rd(paddr) : 8'h00;
    ee = acc && ((pwrite && (paddr == 0 || paddr == 5 || paddr == 6)) ||
                 (!pwrite && paddr == 6 && q.size() == 0));
    if (!(acc && pwrite)) chk("prdata", prdata, ep);
    chk("pslverr", pslverr, ee);
    chk("data_read", data_read, m_ack);
    chk("irq", irq, m_irq);
    chk("bit_period", bit_period, m_bp);
    chk("data_size", data_size, m_ds);
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic apb(input bit wr, input logic [2:0] a, input logic [7:0] d);
    psel = 1; penable = 0; pwrite = wr; paddr = a; pwdata = d;
    step();
    penable = 1;
    step();
    psel = 0; penable = 0; pwrite = 0;
  endtask

  task automatic push_word(input logic [7:0] d);
    rx_data = d; data_ready = 1;
    step();
    data_ready = 0;
    step();
  endtask

  initial begin
    logic [7:0] rst_vals [8];
    rst_vals = '{8'h00, 8'h00, 8'h0A, 8'h00, 8'h08, 8'h00, 8'h00, 8'h00};

    // Reset
    repeat (2) @(posedge clk);
    model_edge();
    #1;
    step();
    rst = 0;
    for (int a = 0; a < 8; a++) begin
      apb(0, 3'(a), 0);
      chk($sformatf("rst_reg%0d", a), last_rd, rst_vals[a]);
      chk($sformatf("rst_err%0d", a), last_err, a == 6);
    end
    chk("rst_bp", bit_period, 10);
    chk("rst_irq", irq, 0);

    // Single word with data_ready held for two cycles
    rx_data = 8'hA5; data_ready = 1;
    step(); step();
    data_ready = 0;
    apb(0, 5, 0); chk("count_one", last_rd, 1);
    apb(0, 6, 0); chk("pop_a5", last_rd, 8'hA5);
    apb(0, 5, 0); chk("count_zero", last_rd, 0);

    // Overflow: nine words into eight slots
    for (int i = 1; i <= 9; i++) push_word(8'(i));
    apb(0, 5, 0); chk("count_full", last_rd, 8);
    apb(0, 0, 0); chk("status_full", last_rd, 8'h03);
    apb(0, 1, 0); chk("err_ovf", last_rd, 8'h04);
    apb(1, 1, 8'h04);
    for (int i = 1; i <= 8; i++) begin
      apb(0, 6, 0); chk($sformatf("drain%0d", i), last_rd, 8'(i));
    end
    apb(0, 6, 0); chk("empty_pop_err", last_err, 1);

    // Full FIFO: pop and push on the same edge
    for (int i = 0; i < 8; i++) push_word(8'h10 + 8'(i));
    psel = 1; penable = 0; pwrite = 0; paddr = 6;
    step();
    penable = 1; rx_data = 8'h18; data_ready = 1;
    step();
    chk("simul_pop", last_rd, 8'h10);
    psel = 0; penable = 0; data_ready = 0;
    step();
    apb(0, 5, 0); chk("simul_count", last_rd, 8);
    apb(0, 1, 0); chk("simul_no_ovf", last_rd, 0);
    for (int i = 0; i < 3; i++) begin
      apb(0, 6, 0); chk($sformatf("wrap_pop%0d", i), last_rd, 8'h11 + 8'(i));
      push_word(8'h19 + 8'(i));
    end
    for (int i = 0; i < 8; i++) begin
      apb(0, 6, 0); chk($sformatf("wrap_order%0d", i), last_rd, 8'h14 + 8'(i));
    end

    // Sticky framing error and set-beats-clear
    framing_error = 1; step(); framing_error = 0; step();
    apb(0, 1, 0); chk("frm_sticky", last_rd, 8'h01);
    framing_error = 1;
    apb(1, 1, 8'h01);
    framing_error = 0;
    apb(0, 1, 0); chk("frm_set_wins", last_rd, 8'h01);
    apb(1, 1, 8'h01);
    apb(0, 1, 0); chk("frm_cleared", last_rd, 8'h00);

    // Interrupt, bit_period and read-only write
    apb(1, 7, 8'h01);
    chk("irq_idle", irq, 0);
    rx_data = 8'h5A; data_ready = 1;
    step();
    chk("irq_after_push", irq, 1);
    data_ready = 0;
    step();
    apb(0, 6, 0);
    chk("irq_after_pop", irq, 0);
    apb(1, 2, 8'h34);
    apb(1, 3, 8'h12);
    chk("bp_1234", bit_period, 14'h1234);
    apb(1, 3, 8'hFF);
    apb(0, 3, 0); chk("bp_hi_mask", last_rd, 8'h3F);
    apb(1, 0, 8'hFF); chk("ro_write_err", last_err, 1);

    // Randomised traffic against the model
    for (int i = 0; i < 600; i++) begin
      logic [2:0] a;
      rx_data       = 8'($urandom);
      data_ready    = 1'($urandom_range(0, 1));
      framing_error = ($urandom_range(0, 15) == 0);
      overrun_error = ($urandom_range(0, 15) == 0);
      rst           = ($urandom_range(0, 199) == 0);
      case ($urandom_range(0, 3))
        0: step();
        1, 2: begin
          a = $urandom_range(0, 1) ? 3'd6 : 3'($urandom_range(0, 7));
          apb(0, a, 0);
        end
        default: apb(1, 3'($urandom_range(0, 7)), 8'($urandom));
      endcase
    end
    rst = 0; data_ready = 0; framing_error = 0; overrun_error = 0;
    repeat (3) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
